// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Load/run/dump sequencer for the single-cycle mips32 core.
//               First it streams an instruction image into imem while the
//               core is held in reset. Then it enables the core for a bounded
//               number of cycles or until a halt. Last, it streams the
//               register file out.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8,
    parameter int RF_DEPTH   = 32,
    parameter int RUN_CYCLES = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              cpu_en,
    input  logic              cpu_halt,
    output logic [4:0]        rf_rd_addr,
    input  logic [31:0]       rf_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       cycle_count
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_DUMP = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [15:0]       c_RUN_LAST  = 16'(RUN_CYCLES - 1);
    localparam logic [4:0]        c_DUMP_LAST = 5'(RF_DEPTH - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [15:0]       r_cycle;
    logic [4:0]        r_didx;

    logic w_in_load;
    logic w_in_run;
    logic w_in_dump;
    logic w_load_fire;

    assign w_in_load   = (r_state == c_LOAD);
    assign w_in_run    = (r_state == c_RUN);
    assign w_in_dump   = (r_state == c_DUMP);
    assign w_load_fire = w_in_load && load_valid;

    // Outputs are decoded from the state register; the write strobe and the
    // halt gating are combinational, so a write has zero latency and a halt
    // instruction is never committed.
    assign load_ready  = w_in_load;
    assign imem_we     = w_load_fire;
    assign imem_addr   = w_in_load ? r_waddr : '0;
    assign imem_wdata  = w_load_fire ? load_data : '0;
    assign cpu_rst     = (r_state == c_IDLE) || w_in_load;
    assign cpu_en      = w_in_run && !cpu_halt;
    assign rf_rd_addr  = w_in_dump ? r_didx : '0;
    assign dump_valid  = w_in_dump;
    assign dump_data   = w_in_dump ? rf_rd_data : '0;
    assign dump_last   = w_in_dump && (r_didx == c_DUMP_LAST);
    assign busy        = w_in_load || w_in_run || w_in_dump;
    assign done        = (r_state == c_DONE);
    assign cycle_count = r_cycle;

    // Sequencer: state, load word address, run cycle counter and dump index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_waddr <= '0;
            r_cycle <= '0;
            r_didx  <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state <= c_LOAD;
                        r_waddr <= '0;
                    end
                end
                c_LOAD: begin
                    if (load_valid) begin
                        // The address saturates at the top word instead of wrapping.
                        if (r_waddr != c_ADDR_LAST) begin
                            r_waddr <= r_waddr + 1'b1;
                        end
                        if (load_last || (r_waddr == c_ADDR_LAST)) begin
                            r_state <= c_RUN;
                            r_cycle <= '0;
                        end
                    end
                end
                c_RUN: begin
                    if (cpu_halt) begin
                        // When a halt and the cycle limit coincide, the halt wins.
                        // The cycle is not enabled, so it is not counted.
                        r_state <= c_DUMP;
                        r_didx  <= '0;
                    end else begin
                        r_cycle <= r_cycle + 1'b1;
                        if (r_cycle == c_RUN_LAST) begin
                            r_state <= c_DUMP;
                            r_didx  <= '0;
                        end
                    end
                end
                c_DUMP: begin
                    if (dump_ready) begin
                        if (r_didx == c_DUMP_LAST) begin
                            r_state <= c_DONE;
                        end else begin
                            r_didx <= r_didx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl. It has a scoreboard for
//               imem writes and for register dump words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int IMEM_DEPTH = 256;
    localparam int ADDR_W     = 8;
    localparam int RF_DEPTH   = 32;
    localparam int RUN_CYCLES = 20;

    logic              clk;
    logic              rst;
    logic              start;
    logic              load_valid;
    logic              load_ready;
    logic [31:0]       load_data;
    logic              load_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              cpu_en;
    logic              cpu_halt;
    logic [4:0]        rf_rd_addr;
    logic [31:0]       rf_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [31:0]       dump_data;
    logic              dump_last;
    logic              busy;
    logic              done;
    logic [15:0]       cycle_count;

    logic [31:0]       rf [RF_DEPTH];
    logic [ADDR_W+31:0] load_q [$];
    logic [31:0]       dump_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cycles;
    bit hold_valid;
    bit rst_hit;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_addr];

    cpu_run_ctrl #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W),
        .RF_DEPTH   (RF_DEPTH),
        .RUN_CYCLES (RUN_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_rst     (cpu_rst),
        .cpu_en      (cpu_en),
        .cpu_halt    (cpu_halt),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_last   (dump_last),
        .busy        (busy),
        .done        (done),
        .cycle_count (cycle_count)
    );

    task automatic do_start;
        @(negedge clk);
        start = 1'b1;
        #1;
        n_checks++;
        if ({load_ready, busy} !== 2'b00)
            $display("FAIL start_idle: ready/busy got %b expected 00", {load_ready, busy});
        else n_pass++;
    endtask

    task automatic load_words(input int n, input int last_at, output int acc);
        logic [ADDR_W-1:0]  mdl_addr;
        bit                 mdl_done;
        logic [ADDR_W+31:0] exp;
        mdl_addr = '0;
        mdl_done = 1'b0;
        acc      = 0;
        for (int i = 0; i < n && !mdl_done; i++) begin
            @(negedge clk);
            start      = (i == 1);
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = (i == last_at);
            #1;
            n_checks++;
            if ({load_ready, cpu_rst, cpu_en, busy} !== 4'b1101)
                $display("FAIL load_ctl i=%0d: rdy/rst/en/busy got %b expected 1101", i,
                         {load_ready, cpu_rst, cpu_en, busy});
            else n_pass++;
            load_q.push_back({mdl_addr, load_data});
            acc++;
            if (load_last || mdl_addr == ADDR_W'(IMEM_DEPTH - 1)) mdl_done = 1'b1;
            else mdl_addr = mdl_addr + 1'b1;
            exp = load_q.pop_front();
            n_checks++;
            if ({imem_we, imem_addr, imem_wdata} !== {1'b1, exp})
                $display("FAIL imem_write i=%0d: we/addr/data got %b/%h/%h expected 1/%h/%h", i,
                         imem_we, imem_addr, imem_wdata, exp[ADDR_W+31:32], exp[31:0]);
            else n_pass++;
        end
    endtask

    task automatic run_phase(input int halt_at, input int rst_at);
        int cnt;
        cnt     = 0;
        rst_hit = 1'b0;
        for (int c = 1; c <= RUN_CYCLES + 1; c++) begin
            @(negedge clk);
            load_valid = hold_valid;
            load_last  = 1'b0;
            start      = (c == 2);
            cpu_halt   = (c == halt_at);
            rst        = (c == rst_at);
            #1;
            n_checks++;
            if ({cpu_rst, cpu_en, busy, done, dump_valid, load_ready, imem_we} !==
                {1'b0, 1'(c != halt_at), 1'b1, 4'b0000})
                $display("FAIL run_ctl c=%0d: rst/en/busy/done/dv/rdy/we got %b expected 0%b10000",
                         c, {cpu_rst, cpu_en, busy, done, dump_valid, load_ready, imem_we},
                         1'(c != halt_at));
            else n_pass++;
            n_checks++;
            if (cycle_count !== 16'(cnt))
                $display("FAIL run_count c=%0d: got %0d expected %0d", c, cycle_count, cnt);
            else n_pass++;
            if (c == rst_at) begin
                rst_hit = 1'b1;
                break;
            end
            if (c == halt_at) break;
            cnt++;
            if (cnt == RUN_CYCLES) break;
        end
        exp_cycles = cnt;
    endtask

    task automatic dump_phase(input logic [3:0] pat);
        int idx;
        int k;
        idx = 0;
        k   = 0;
        for (int i = 0; i < RF_DEPTH; i++) begin
            rf[i] = $urandom;
            dump_q.push_back(rf[i]);
        end
        while (idx < RF_DEPTH && k < 200) begin
            @(negedge clk);
            cpu_halt   = 1'b0;
            load_valid = 1'b0;
            load_last  = 1'b0;
            start      = 1'b0;
            dump_ready = pat[k % 4];
            #1;
            n_checks++;
            if ({dump_valid, busy, done, cpu_en, cpu_rst} !== 5'b11000)
                $display("FAIL dump_ctl k=%0d: dv/busy/done/en/rst got %b expected 11000", k,
                         {dump_valid, busy, done, cpu_en, cpu_rst});
            else n_pass++;
            n_checks++;
            if (cycle_count !== 16'(exp_cycles))
                $display("FAIL dump_count k=%0d: got %0d expected %0d", k, cycle_count, exp_cycles);
            else n_pass++;
            n_checks++;
            if ({rf_rd_addr, dump_last, dump_data} !== {5'(idx), 1'(idx == RF_DEPTH - 1), dump_q[0]})
                $display("FAIL dump_word k=%0d: addr/last/data got %0d/%b/%h expected %0d/%b/%h", k,
                         rf_rd_addr, dump_last, dump_data, idx, idx == RF_DEPTH - 1, dump_q[0]);
            else n_pass++;
            if (dump_ready) begin
                dump_q.delete(0);
                idx++;
            end
            k++;
        end
        n_checks++;
        if (idx < RF_DEPTH)
            $display("FAIL dump_timeout: got %0d words expected %0d", idx, RF_DEPTH);
        else n_pass++;
        @(negedge clk);
        dump_ready = 1'b0;
        #1;
        n_checks++;
        if ({done, busy, dump_valid, cpu_en, cpu_rst, load_ready} !== 6'b100000 ||
            cycle_count !== 16'(exp_cycles))
            $display("FAIL done_state: done/busy/dv/en/rst/rdy got %b cnt %0d expected 100000 cnt %0d",
                     {done, busy, dump_valid, cpu_en, cpu_rst, load_ready}, cycle_count, exp_cycles);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({load_ready, imem_we, cpu_rst, cpu_en, dump_valid, dump_last, busy, done} !== 8'b00100000 ||
            imem_addr !== '0 || rf_rd_addr !== '0 || cycle_count !== 16'd0)
            $display("FAIL reset_vals: flags %b addr %h rf %h cnt %0d expected 00100000/0/0/0",
                     {load_ready, imem_we, cpu_rst, cpu_en, dump_valid, dump_last, busy, done},
                     imem_addr, rf_rd_addr, cycle_count);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_nominal;
        int acc;
        do_start();
        load_words(4, 3, acc);
        n_checks++;
        if (acc !== 4) $display("FAIL nominal_words: got %0d expected 4", acc);
        else n_pass++;
        hold_valid = 1'b0;
        run_phase(0, 0);
        dump_phase(4'b1111);
    endtask

    task automatic test_early_halt;
        int acc;
        do_start();
        load_words(3, 2, acc);
        run_phase(7, 0);
        n_checks++;
        if (exp_cycles !== 6) $display("FAIL halt_cycles: got %0d expected 6", exp_cycles);
        else n_pass++;
        dump_phase(4'b1111);
    endtask

    task automatic test_overflow;
        int acc;
        do_start();
        load_words(300, -1, acc);
        n_checks++;
        if (acc !== IMEM_DEPTH) $display("FAIL overflow_words: got %0d expected %0d", acc, IMEM_DEPTH);
        else n_pass++;
        hold_valid = 1'b1;
        run_phase(0, 0);
        hold_valid = 1'b0;
        dump_phase(4'b1111);
    endtask

    task automatic test_backpressure;
        int acc;
        do_start();
        load_words(2, 1, acc);
        run_phase(0, 0);
        dump_phase(4'b1001);
    endtask

    task automatic test_mid_run_reset;
        int acc;
        do_start();
        load_words(5, 4, acc);
        run_phase(0, 10);
        n_checks++;
        if (!rst_hit) $display("FAIL midrst_reach: got %b expected 1", rst_hit);
        else n_pass++;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        n_checks++;
        if ({cpu_rst, cpu_en, busy, done, load_ready} !== 5'b10000 || cycle_count !== 16'd0)
            $display("FAIL midrst_idle: rst/en/busy/done/rdy got %b cnt %0d expected 10000 cnt 0",
                     {cpu_rst, cpu_en, busy, done, load_ready}, cycle_count);
        else n_pass++;
        do_start();
        load_words(2, 1, acc);
        run_phase(0, 0);
        dump_phase(4'b1111);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        cpu_halt   = 1'b0;
        dump_ready = 1'b0;
        hold_valid = 1'b0;
        for (int i = 0; i < RF_DEPTH; i++) rf[i] = '0;
        test_reset();
        test_nominal();
        test_early_halt();
        test_overflow();
        test_backpressure();
        test_mid_run_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-sequencing controller for the single-cycle mips32 core. It loads instruction memory over a valid/ready stream with the core held in reset, then enables the core for a bounded number of cycles or until a halt. It then streams all architectural registers out over a second valid/ready port. This replaces load-run-dump sequencing done by hand in simulation and makes the core usable behind a host link.

## Interface
Parameters:
- IMEM_DEPTH, 256: instruction memory words; power of two.
- ADDR_W, 8: log2(IMEM_DEPTH).
- RF_DEPTH, 32: registers dumped.
- RUN_CYCLES, 20: maximum enabled core cycles per run; must be ≥1, < 65536.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load/run/dump sequence; sampled only in IDLE or DONE.
- load_valid  in  1  host word valid.
- load_ready  out  1  controller accepts a load word.
- load_data  in  32  instruction word.
- load_last  in  1  marks the final instruction word.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  instruction memory write address.
- imem_wdata  out  32  instruction memory write data.
- cpu_rst  out  1  core reset (PC, state).
- cpu_en  out  1  core clock enable (PC update, register/data memory writes).
- cpu_halt  in  1  core decoded a halt instruction this cycle.
- rf_rd_addr  out  5  register file debug read address (asynchronous read).
- rf_rd_data  in  32  register file debug read data.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  host accepts dump word.
- dump_data  out  32  register value.
- dump_last  out  1  marks register RF_DEPTH-1.
- busy  out  1  high in LOAD, RUN, DUMP.
- done  out  1  high in DONE.
- cycle_count  out  16  enabled cycles executed in the last or current run.

## Operation
- States: IDLE, LOAD, RUN, DUMP, DONE. Reset state is IDLE.
- IDLE:
  - cpu_rst=1; all other outputs 0.
  - start → LOAD; word address cleared.
- LOAD:
  - load_ready=1; cpu_rst=1.
  - On load_valid&&load_ready: imem_we=1, imem_addr=word address, imem_wdata=load_data (combinational pass-through); word address increments.
  - Leave for RUN after the accepted word with load_last=1, or after the accepted word at address IMEM_DEPTH-1, whichever comes first. The address never wraps.
  - Entry to RUN clears cycle_count.
- RUN:
  - cpu_rst=0.
  - cpu_en = !cpu_halt (combinational), so a halt instruction never commits.
  - cycle_count increments on every cycle with cpu_en=1.
  - Go to DUMP when cpu_halt=1, or on the cycle cycle_count reaches RUN_CYCLES (the cycle with count RUN_CYCLES-1 and cpu_en=1 is the last enabled cycle). If both hold in the same cycle, halt wins; the result is still DUMP.
- DUMP:
  - cpu_en=0, cpu_rst=0; core state is frozen.
  - rf_rd_addr = dump index; dump_data = rf_rd_data; dump_valid=1; dump_last = (index==RF_DEPTH-1).
  - Index increments on dump_valid&&dump_ready. After the last word is accepted → DONE.
  - dump_data and dump_last stay stable while dump_ready=0.
- DONE:
  - done=1; core stays frozen (cpu_en=0, cpu_rst=0); cycle_count is held.
  - start → LOAD; a new image overwrites memory from address 0.
- start is ignored in LOAD, RUN and DUMP.
- rst at any point: next state is IDLE; cycle_count, word address and dump index are cleared. Memory contents already written are not erased.

## Timing
- Reset values: load_ready=0, imem_we=0, imem_addr=0, cpu_rst=1, cpu_en=0, rf_rd_addr=0, dump_valid=0, dump_last=0, busy=0, done=0, cycle_count=0.
- start sampled at edge N → LOAD visible at N+1; load_ready=1 from N+1.
- Write latency is zero: the imem write occurs on the same edge as the handshake.
- Final load word accepted at edge M → RUN from M+1; cpu_en=1 from M+1.
- With no halt, cpu_en is high for exactly RUN_CYCLES consecutive cycles; DUMP begins the following cycle.
- First dump word is valid on the first DUMP cycle. With dump_ready held high, DUMP lasts RF_DEPTH cycles and DONE follows on the next cycle.

## Test plan
- Nominal: start, 4 words with load_last on the 4th, dump_ready=1 → imem addresses 0..3 written; cpu_en high exactly 20 cycles; cycle_count=20; 32 dump words for regs 0..31; dump_last on the 32nd; done=1 the next cycle.
- Early halt: cpu_halt asserted on the 7th RUN cycle → cpu_en=0 that cycle; cycle_count=6; DUMP on the next cycle.
- Load overflow: 300 words, no load_last, IMEM_DEPTH=256 → writes to addresses 0..255 only; load_ready low after the 256th accept; RUN entered.
- Backpressure: dump_ready toggled 1,0,0,1 → dump_data and dump_last hold during the 0 cycles; no register skipped or repeated.
- Mid-run reset: rst on the 10th RUN cycle → IDLE next cycle; cpu_rst=1, cpu_en=0, cycle_count=0; a later start reloads from address 0.
- start pulses during LOAD and RUN → no effect on state or addresses; start in DONE restarts the sequence.
